// File: rtl/tx_packet_arbiter_pkg.sv
`default_nettype none
// ============================================================================
// Module   : tx_packet_arbiter_pkg
// Brief    : Shared FSM encoding, header tag and requester ids for the arbiter
// Revision : 1.0
// ============================================================================
package tx_packet_arbiter_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_HEADER = 2'd1,
        ST_DATA   = 2'd2
    } state_t;

    localparam logic [4:0] HDR_TAG_DEFAULT = 5'b10100;
    localparam int         REQ_MCP         = 0;
    localparam int         REQ_CCD         = 1;

    function automatic logic [7:0] make_header(input logic [4:0] tag, input logic [2:0] id);
        return {tag, id};
    endfunction

endpackage
`default_nettype wire

// File: rtl/tx_packet_arbiter_rr_pick.sv
`default_nettype none
// ============================================================================
// Module   : tx_packet_arbiter_rr_pick
// Brief    : Combinational round-robin picker, search starts after last_grant
// Revision : 1.0
// ============================================================================
module tx_packet_arbiter_rr_pick #(
    parameter int NUM_REQ = 2
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [2:0]         last_grant,
    output logic [2:0]         winner,
    output logic               found
);
    localparam int IDXW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    logic [IDXW-1:0] idx;

    always_comb begin
        winner = last_grant;
        found  = 1'b0;
        idx    = '0;
        for (int off = 1; off <= NUM_REQ; off++) begin
            idx = IDXW'((32'(last_grant) + 32'(off)) % 32'(NUM_REQ));
            if (!found && req[idx]) begin
                found  = 1'b1;
                winner = 3'(idx);
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/tx_packet_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tx_packet_arbiter
// Brief    : Round-robin packet arbiter for the tx FIFO write port, with header
// Revision : 1.0
// ============================================================================
module tx_packet_arbiter
    import tx_packet_arbiter_pkg::*;
#(
    parameter int         NUM_REQ = 2,
    parameter logic [4:0] HDR_TAG = HDR_TAG_DEFAULT,
    parameter int         MAX_LEN = 4096
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   enable,
    input  logic [NUM_REQ-1:0]     req_valid,
    input  logic [8*NUM_REQ-1:0]   req_data,
    input  logic [NUM_REQ-1:0]     req_last,
    output logic [NUM_REQ-1:0]     req_ready,
    input  logic                   tx_fifo_wfull,
    output logic                   tx_fifo_winc,
    output logic [7:0]             tx_fifo_wdata,
    output logic                   busy,
    output logic [2:0]             grant_id,
    output logic                   trunc_err
);
    localparam int              IDXW     = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int              CNT_W    = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(MAX_LEN - 1);

    state_t           state_q, state_d;
    logic [2:0]       grant_q, grant_d;
    logic [CNT_W-1:0] byte_cnt_q, byte_cnt_d;
    logic             trunc_err_q, trunc_err_d;

    logic [2:0]       pick_id;
    logic             pick_found;
    logic [IDXW-1:0]  g_idx;
    logic             g_valid;
    logic             g_last;
    logic [7:0]       g_data;

    tx_packet_arbiter_rr_pick #(
        .NUM_REQ (NUM_REQ)
    ) u_rr_pick (
        .req        (req_valid),
        .last_grant (grant_q),
        .winner     (pick_id),
        .found      (pick_found)
    );

    // grant_q doubles as last_grant: it keeps the previous winner while idle
    assign g_idx   = grant_q[IDXW-1:0];
    assign g_valid = req_valid[g_idx];
    assign g_last  = req_last[g_idx];
    assign g_data  = req_data[{g_idx, 3'b000} +: 8];

    always_comb begin
        state_d       = state_q;
        grant_d       = grant_q;
        byte_cnt_d    = byte_cnt_q;
        trunc_err_d   = 1'b0;
        tx_fifo_winc  = 1'b0;
        tx_fifo_wdata = 8'h00;
        req_ready     = '0;
        case (state_q)
            ST_IDLE: begin
                if (enable && pick_found) begin
                    grant_d    = pick_id;
                    byte_cnt_d = '0;
                    state_d    = ST_HEADER;
                end
            end
            ST_HEADER: begin
                if (!tx_fifo_wfull) begin
                    tx_fifo_winc  = 1'b1;
                    tx_fifo_wdata = make_header(HDR_TAG, grant_q);
                    state_d       = ST_DATA;
                end
            end
            ST_DATA: begin
                if (g_valid && !tx_fifo_wfull) begin
                    req_ready[g_idx] = 1'b1;
                    tx_fifo_winc     = 1'b1;
                    tx_fifo_wdata    = g_data;
                    byte_cnt_d       = byte_cnt_q + 1'b1;
                    // a real last byte at the length limit is a normal end
                    if (g_last) begin
                        state_d = ST_IDLE;
                    end else if (byte_cnt_q == LAST_CNT) begin
                        state_d     = ST_IDLE;
                        trunc_err_d = 1'b1;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            grant_q     <= 3'(NUM_REQ - 1);
            byte_cnt_q  <= '0;
            trunc_err_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            grant_q     <= grant_d;
            byte_cnt_q  <= byte_cnt_d;
            trunc_err_q <= trunc_err_d;
        end
    end

    assign busy      = (state_q != ST_IDLE);
    assign grant_id  = grant_q;
    assign trunc_err = trunc_err_q;

endmodule
`default_nettype wire

// File: tb/tb_tx_packet_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_tx_packet_arbiter
// Brief    : Directed bench; u_dut uses MAX_LEN 4096, u_trunc uses MAX_LEN 4
// Revision : 1.0
// ============================================================================
module tb_tx_packet_arbiter;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        enable;
    logic [1:0]  req_valid;
    logic [15:0] req_data;
    logic [1:0]  req_last;
    logic        wfull;

    logic [1:0]  rdy_a, rdy_b;
    logic        winc_a, winc_b;
    logic [7:0]  wdata_a, wdata_b;
    logic        busy_a, busy_b;
    logic [2:0]  gid_a, gid_b;
    logic        trunc_a, trunc_b;

    logic        use_b;
    logic [1:0]  ready_s;
    logic        winc_s, busy_s, trunc_s;
    logic [7:0]  wdata_s;
    logic [2:0]  gid_s;

    logic [7:0]  src_data [2][8];
    logic        src_last [2][8];
    int          src_len  [2];
    int          src_ptr  [2];

    int          n_checks = 0;
    int          n_err    = 0;

    always #5 clk = ~clk;

    tx_packet_arbiter u_dut (
        .clk(clk), .rst_n(rst_n), .enable(enable),
        .req_valid(req_valid), .req_data(req_data), .req_last(req_last),
        .req_ready(rdy_a), .tx_fifo_wfull(wfull), .tx_fifo_winc(winc_a),
        .tx_fifo_wdata(wdata_a), .busy(busy_a), .grant_id(gid_a), .trunc_err(trunc_a)
    );

    tx_packet_arbiter #(.MAX_LEN(4)) u_trunc (
        .clk(clk), .rst_n(rst_n), .enable(enable),
        .req_valid(req_valid), .req_data(req_data), .req_last(req_last),
        .req_ready(rdy_b), .tx_fifo_wfull(wfull), .tx_fifo_winc(winc_b),
        .tx_fifo_wdata(wdata_b), .busy(busy_b), .grant_id(gid_b), .trunc_err(trunc_b)
    );

    assign ready_s = use_b ? rdy_b   : rdy_a;
    assign winc_s  = use_b ? winc_b  : winc_a;
    assign wdata_s = use_b ? wdata_b : wdata_a;
    assign busy_s  = use_b ? busy_b  : busy_a;
    assign gid_s   = use_b ? gid_b   : gid_a;
    assign trunc_s = use_b ? trunc_b : trunc_a;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic drive();
        for (int i = 0; i < 2; i++) begin
            if (src_ptr[i] < src_len[i]) begin
                req_valid[i]       = 1'b1;
                req_data[8*i +: 8] = src_data[i][src_ptr[i]];
                req_last[i]        = src_last[i][src_ptr[i]];
            end else begin
                req_valid[i]       = 1'b0;
                req_data[8*i +: 8] = 8'h00;
                req_last[i]        = 1'b0;
            end
        end
    endtask

    task automatic load(input int i, input logic [7:0] b0, input logic [7:0] st,
                        input int n, input logic [7:0] lmask);
        for (int k = 0; k < 8; k++) begin
            src_data[i][k] = b0 + 8'(k) * st;
            src_last[i][k] = lmask[k];
        end
        src_len[i] = n;
        src_ptr[i] = 0;
    endtask

    // One clock: check combinational outputs at negedge, then let requesters pop
    task automatic step(input string tag, input logic [8:0] ew, input logic [1:0] er,
                        input logic eb, input logic et);
        logic [1:0] rs;
        @(negedge clk);
        chk($sformatf("%s.w", tag),     32'({winc_s, wdata_s}), 32'(ew));
        chk($sformatf("%s.rdy", tag),   32'(ready_s), 32'(er));
        chk($sformatf("%s.busy", tag),  32'(busy_s),  32'(eb));
        chk($sformatf("%s.trunc", tag), 32'(trunc_s), 32'(et));
        rs = ready_s;
        @(posedge clk);
        #1;
        for (int i = 0; i < 2; i++) if (rs[i]) src_ptr[i]++;
        drive();
    endtask

    task automatic do_reset(input string tag);
        rst_n = 1'b0;
        #1;
        chk($sformatf("%s.winc", tag),  32'(winc_a),  32'd0);
        chk($sformatf("%s.wdata", tag), 32'(wdata_a), 32'd0);
        chk($sformatf("%s.rdy", tag),   32'(rdy_a),   32'd0);
        chk($sformatf("%s.busy", tag),  32'(busy_a),  32'd0);
        chk($sformatf("%s.gid", tag),   32'(gid_a),   32'd1);
        chk($sformatf("%s.trunc", tag), 32'(trunc_a), 32'd0);
        chk($sformatf("%s.b_winc", tag), 32'(winc_b), 32'd0);
        chk($sformatf("%s.b_gid", tag),  32'(gid_b),  32'd1);
        src_len[0] = 0;
        src_len[1] = 0;
        src_ptr[0] = 0;
        src_ptr[1] = 0;
        wfull      = 1'b0;
        enable     = 1'b1;
        drive();
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst_n = 1'b1; enable = 1'b1; wfull = 1'b0; use_b = 1'b0;
        src_len[0] = 0; src_len[1] = 0; src_ptr[0] = 0; src_ptr[1] = 0;
        drive();
        #2;

        // single MCP packet
        do_reset("t1rst");
        load(0, 8'h11, 8'h11, 4, 8'b0000_1000); drive();
        step("t1c0", 9'h000, 2'b00, 1'b0, 1'b0);
        step("t1c1", 9'h1A0, 2'b00, 1'b1, 1'b0);
        step("t1c2", 9'h111, 2'b01, 1'b1, 1'b0);
        step("t1c3", 9'h122, 2'b01, 1'b1, 1'b0);
        step("t1c4", 9'h133, 2'b01, 1'b1, 1'b0);
        step("t1c5", 9'h144, 2'b01, 1'b1, 1'b0);
        step("t1c6", 9'h000, 2'b00, 1'b0, 1'b0);

        // round-robin with both requesters always valid
        do_reset("t2rst");
        load(0, 8'h01, 8'h01, 4, 8'b0000_1010);
        load(1, 8'h81, 8'h01, 4, 8'b0000_1010); drive();
        step("t2c0", 9'h000, 2'b00, 1'b0, 1'b0);
        step("t2c1", 9'h1A0, 2'b00, 1'b1, 1'b0);
        step("t2c2", 9'h101, 2'b01, 1'b1, 1'b0);
        step("t2c3", 9'h102, 2'b01, 1'b1, 1'b0);
        step("t2c4", 9'h000, 2'b00, 1'b0, 1'b0);
        chk("t2gid", 32'(gid_s), 32'd1);
        step("t2c5", 9'h1A1, 2'b00, 1'b1, 1'b0);
        step("t2c6", 9'h181, 2'b10, 1'b1, 1'b0);
        step("t2c7", 9'h182, 2'b10, 1'b1, 1'b0);
        step("t2c8", 9'h000, 2'b00, 1'b0, 1'b0);
        step("t2c9", 9'h1A0, 2'b00, 1'b1, 1'b0);
        step("t2c10", 9'h103, 2'b01, 1'b1, 1'b0);
        step("t2c11", 9'h104, 2'b01, 1'b1, 1'b0);
        step("t2c12", 9'h000, 2'b00, 1'b0, 1'b0);
        step("t2c13", 9'h1A1, 2'b00, 1'b1, 1'b0);
        step("t2c14", 9'h183, 2'b10, 1'b1, 1'b0);
        step("t2c15", 9'h184, 2'b10, 1'b1, 1'b0);
        step("t2c16", 9'h000, 2'b00, 1'b0, 1'b0);

        // three cycles of FIFO-full in the middle of data
        do_reset("t3rst");
        load(0, 8'h51, 8'h01, 5, 8'b0001_0000); drive();
        step("t3c0", 9'h000, 2'b00, 1'b0, 1'b0);
        step("t3c1", 9'h1A0, 2'b00, 1'b1, 1'b0);
        step("t3c2", 9'h151, 2'b01, 1'b1, 1'b0);
        step("t3c3", 9'h152, 2'b01, 1'b1, 1'b0);
        wfull = 1'b1;
        step("t3c4", 9'h000, 2'b00, 1'b1, 1'b0);
        step("t3c5", 9'h000, 2'b00, 1'b1, 1'b0);
        step("t3c6", 9'h000, 2'b00, 1'b1, 1'b0);
        wfull = 1'b0;
        step("t3c7", 9'h153, 2'b01, 1'b1, 1'b0);
        step("t3c8", 9'h154, 2'b01, 1'b1, 1'b0);
        step("t3c9", 9'h155, 2'b01, 1'b1, 1'b0);
        step("t3c10", 9'h000, 2'b00, 1'b0, 1'b0);

        // enable dropped after the header
        do_reset("t4rst");
        load(0, 8'h61, 8'h01, 3, 8'b0000_0100);
        load(1, 8'h71, 8'h01, 2, 8'b0000_0010); drive();
        step("t4c0", 9'h000, 2'b00, 1'b0, 1'b0);
        step("t4c1", 9'h1A0, 2'b00, 1'b1, 1'b0);
        enable = 1'b0;
        step("t4c2", 9'h161, 2'b01, 1'b1, 1'b0);
        step("t4c3", 9'h162, 2'b01, 1'b1, 1'b0);
        step("t4c4", 9'h163, 2'b01, 1'b1, 1'b0);
        step("t4c5", 9'h000, 2'b00, 1'b0, 1'b0);
        step("t4c6", 9'h000, 2'b00, 1'b0, 1'b0);
        step("t4c7", 9'h000, 2'b00, 1'b0, 1'b0);
        enable = 1'b1;
        step("t4c8", 9'h000, 2'b00, 1'b0, 1'b0);
        step("t4c9", 9'h1A1, 2'b00, 1'b1, 1'b0);
        step("t4c10", 9'h171, 2'b10, 1'b1, 1'b0);
        step("t4c11", 9'h172, 2'b10, 1'b1, 1'b0);
        step("t4c12", 9'h000, 2'b00, 1'b0, 1'b0);

        // asynchronous reset while in DATA
        do_reset("t5rst0");
        load(0, 8'h91, 8'h01, 4, 8'b0000_1000);
        load(1, 8'hC1, 8'h01, 2, 8'b0000_0010); drive();
        step("t5c0", 9'h000, 2'b00, 1'b0, 1'b0);
        step("t5c1", 9'h1A0, 2'b00, 1'b1, 1'b0);
        step("t5c2", 9'h191, 2'b01, 1'b1, 1'b0);
        chk("t5pre", 32'(winc_s), 32'd1);
        #2;
        do_reset("t5rst");
        load(0, 8'hD1, 8'h01, 2, 8'b0000_0010);
        load(1, 8'hC1, 8'h01, 2, 8'b0000_0010); drive();
        step("t5d0", 9'h000, 2'b00, 1'b0, 1'b0);
        step("t5d1", 9'h1A0, 2'b00, 1'b1, 1'b0);
        step("t5d2", 9'h1D1, 2'b01, 1'b1, 1'b0);
        step("t5d3", 9'h1D2, 2'b01, 1'b1, 1'b0);
        step("t5d4", 9'h000, 2'b00, 1'b0, 1'b0);
        step("t5d5", 9'h1A1, 2'b00, 1'b1, 1'b0);
        step("t5d6", 9'h1C1, 2'b10, 1'b1, 1'b0);
        step("t5d7", 9'h1C2, 2'b10, 1'b1, 1'b0);
        step("t5d8", 9'h000, 2'b00, 1'b0, 1'b0);

        // truncation at MAX_LEN = 4, remainder becomes a new packet
        do_reset("t6rst");
        use_b = 1'b1;
        load(1, 8'hE1, 8'h01, 6, 8'b0010_0000); drive();
        step("t6c0", 9'h000, 2'b00, 1'b0, 1'b0);
        step("t6c1", 9'h1A1, 2'b00, 1'b1, 1'b0);
        step("t6c2", 9'h1E1, 2'b10, 1'b1, 1'b0);
        step("t6c3", 9'h1E2, 2'b10, 1'b1, 1'b0);
        step("t6c4", 9'h1E3, 2'b10, 1'b1, 1'b0);
        step("t6c5", 9'h1E4, 2'b10, 1'b1, 1'b0);
        step("t6c6", 9'h000, 2'b00, 1'b0, 1'b1);
        step("t6c7", 9'h1A1, 2'b00, 1'b1, 1'b0);
        step("t6c8", 9'h1E5, 2'b10, 1'b1, 1'b0);
        step("t6c9", 9'h1E6, 2'b10, 1'b1, 1'b0);
        step("t6c10", 9'h000, 2'b00, 1'b0, 1'b0);

        // last byte exactly at MAX_LEN is a normal end
        do_reset("t7rst");
        load(1, 8'hF1, 8'h01, 4, 8'b0000_1000); drive();
        step("t7c0", 9'h000, 2'b00, 1'b0, 1'b0);
        step("t7c1", 9'h1A1, 2'b00, 1'b1, 1'b0);
        step("t7c2", 9'h1F1, 2'b10, 1'b1, 1'b0);
        step("t7c3", 9'h1F2, 2'b10, 1'b1, 1'b0);
        step("t7c4", 9'h1F3, 2'b10, 1'b1, 1'b0);
        step("t7c5", 9'h1F4, 2'b10, 1'b1, 1'b0);
        step("t7c6", 9'h000, 2'b00, 1'b0, 1'b0);
        step("t7c7", 9'h000, 2'b00, 1'b0, 1'b0);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
